// File: rtl/mem_slot_sequencer_if.sv
// Bundles the divider phases, the CPU and video requester ports and the RAM port of the
// slot sequencer. slave is the sequencer's view, master the surrounding system's view.
interface mem_slot_sequencer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_phi;
    logic              mem_phi;
    logic              vid_phi;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              locked;
    logic              sync_err;

    modport master (
        output cpu_phi, mem_phi, vid_phi,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output vid_req, vid_addr,
        input  vid_rdata, vid_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  locked, sync_err
    );

    modport slave (
        input  cpu_phi, mem_phi, vid_phi,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  vid_req, vid_addr,
        output vid_rdata, vid_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output locked, sync_err
    );
endinterface

// File: rtl/mem_slot_sequencer.sv
// Time-slot RAM sequencer: locks a 2-bit slot counter to the divider phases, gives even slots
// to the CPU and odd slots to video, and runs one single-cycle RAM access per slot.
module mem_slot_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input logic                 CLOCK_50,
    input logic                 reset_n,
    mem_slot_sequencer_if.slave bus
);
    logic              p_mem_q;
    logic              p_cpu_q;
    logic [1:0]        slot_q;
    logic [1:0]        slot_d;
    logic              locked_q;
    logic              locked_d;
    logic              sync_err_q;
    logic              sync_err_d;

    logic              mem_rise;
    logic              cpu_rise;
    logic              phase_bad;
    logic              issue_cpu;
    logic              issue_vid;

    logic              cpu_busy_q;
    logic              cpu_busy_d;
    logic              vid_busy_q;
    logic              vid_busy_d;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              own_cpu_q;

    logic              s1_valid_q;
    logic              s1_cpu_q;
    logic              s1_we_q;

    logic              cpu_ack_q;
    logic              vid_valid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    always_comb begin
        mem_rise = bus.mem_phi & ~p_mem_q;
        cpu_rise = bus.cpu_phi & ~p_cpu_q;

        slot_d   = slot_q;
        locked_d = locked_q;
        if (mem_rise) begin
            if (cpu_rise) begin
                slot_d   = 2'd0;
                locked_d = 1'b1;
            end else begin
                slot_d = slot_q + 2'd1;
            end
        end

        phase_bad = (cpu_rise & ~mem_rise)
                  | (cpu_rise & mem_rise & (slot_q != 2'd3))
                  | (mem_rise & ~cpu_rise & (slot_q == 2'd3))
                  | (bus.vid_phi ^ bus.cpu_phi);
        sync_err_d = sync_err_q | (locked_q & phase_bad);

        // The locking edge itself already opens slot 0 for the CPU.
        issue_cpu = mem_rise & locked_d & ~slot_d[0] & bus.cpu_req & ~cpu_busy_q;
        issue_vid = mem_rise & locked_d &  slot_d[0] & bus.vid_req & ~vid_busy_q;

        // Busy spans through the completion pulse so a request still held in that cycle
        // is not taken a second time.
        cpu_busy_d = cpu_busy_q;
        if (issue_cpu) begin
            cpu_busy_d = 1'b1;
        end else if (cpu_ack_q) begin
            cpu_busy_d = 1'b0;
        end

        vid_busy_d = vid_busy_q;
        if (issue_vid) begin
            vid_busy_d = 1'b1;
        end else if (vid_valid_q) begin
            vid_busy_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            p_mem_q    <= 1'b1;
            p_cpu_q    <= 1'b0;
            slot_q     <= 2'd0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
            cpu_busy_q <= 1'b0;
            vid_busy_q <= 1'b0;
        end else begin
            p_mem_q    <= bus.mem_phi;
            p_cpu_q    <= bus.cpu_phi;
            slot_q     <= slot_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
            cpu_busy_q <= cpu_busy_d;
            vid_busy_q <= vid_busy_d;
        end
    end

    // T0: RAM strobe stage.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            own_cpu_q   <= 1'b0;
        end else begin
            mem_en_q  <= issue_cpu | issue_vid;
            mem_we_q  <= issue_cpu & bus.cpu_we;
            own_cpu_q <= issue_cpu;
            if (issue_cpu) begin
                mem_addr_q  <= bus.cpu_addr;
                mem_wdata_q <= bus.cpu_wdata;
            end else if (issue_vid) begin
                mem_addr_q  <= bus.vid_addr;
            end
        end
    end

    // T1: RAM has captured the access; T2: return data and completion pulse.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_cpu_q    <= 1'b0;
            s1_we_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            s1_valid_q  <= mem_en_q;
            s1_cpu_q    <= own_cpu_q;
            s1_we_q     <= mem_we_q;
            cpu_ack_q   <= s1_valid_q & s1_cpu_q;
            vid_valid_q <= s1_valid_q & ~s1_cpu_q;
            if (s1_valid_q & s1_cpu_q & ~s1_we_q) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
            if (s1_valid_q & ~s1_cpu_q) begin
                vid_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_rdata = vid_rdata_q;
    assign bus.locked    = locked_q;
    assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_mem_slot_sequencer.sv
// Bench for mem_slot_sequencer: phase generator, synchronous RAM, slot-level reference model
// with a per-cycle compare, plus directed scenarios with hand-computed expectations.
module tb_mem_slot_sequencer;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic CLOCK_50 = 1'b1;
    logic reset_n;

    mem_slot_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_slot_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: no response within bound (t=%0t)", nm, $time);
    endtask

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous RAM: preloaded with pat(), read data valid the cycle after mem_en.
    logic [7:0] ram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
        forever begin
            @(posedge CLOCK_50);
            if (bus.mem_en === 1'b1) begin
                if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
                else            bus.mem_rdata      <= ram[bus.mem_addr];
            end
        end
    end

    // Divider phases at the minimum ratio: mem period 4, cpu/vid period 16, t=0 after release.
    int t           = 0;
    int phase_t_cur = -1;
    int vid_fault_t = -1;
    int mem_fault_t = -1;
    initial begin
        logic m;
        logic c;
        forever begin
            @(negedge CLOCK_50);
            if (reset_n !== 1'b1) begin
                t = 0;
                phase_t_cur = -1;
                bus.mem_phi = 1'b1;
                bus.cpu_phi = 1'b0;
                bus.vid_phi = 1'b0;
            end else begin
                m = ((t / 2) % 2) == 0;
                c = ((t / 8) % 2) == 1;
                if (t == mem_fault_t)     m = 1'b0;
                if (t == mem_fault_t + 1) m = 1'b1;
                bus.mem_phi = m;
                bus.cpu_phi = c;
                bus.vid_phi = (t == vid_fault_t) ? ~c : c;
                phase_t_cur = t;
                t++;
            end
        end
    end

    // Reference model: tracks slot number, lock and error at slot granularity and schedules
    // each granted access's completion two edges after its slot edge.
    typedef struct {
        int         e;
        bit         cpu;
        bit         we;
        logic [7:0] d;
    } comp_t;

    comp_t       cq[$];
    logic [7:0]  mmem [int];
    bit          pm = 1'b1, pc = 1'b0, lk = 1'b0, er = 1'b0;
    int          slot = 0, ec = 0, cpu_free = 0, vid_free = 0;
    logic        exp_en = 0, exp_we = 0, exp_cack = 0, exp_vval = 0;
    logic [15:0] exp_addr = 0;
    logic [7:0]  exp_wdata = 0, exp_crd = 0, exp_vrd = 0;

    function automatic logic [7:0] mread(input logic [15:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : pat(a);
    endfunction

    initial begin
        bit mr;
        bit cr;
        forever begin
            @(posedge CLOCK_50 or negedge reset_n);
            if (reset_n !== 1'b1) begin
                pm = 1'b1; pc = 1'b0; lk = 1'b0; er = 1'b0; slot = 0; ec = 0;
                cpu_free = 0; vid_free = 0; cq.delete();
                exp_en = 0; exp_we = 0; exp_cack = 0; exp_vval = 0;
                exp_addr = 0; exp_wdata = 0; exp_crd = 0; exp_vrd = 0;
            end else begin
                ec++;
                mr = bus.mem_phi && !pm;
                cr = bus.cpu_phi && !pc;
                pm = bus.mem_phi;
                pc = bus.cpu_phi;
                if (lk && ((cr && !mr) || (cr && mr && slot != 3) || (mr && !cr && slot == 3) ||
                           (bus.vid_phi != bus.cpu_phi)))
                    er = 1'b1;
                if (mr) begin
                    if (cr) begin slot = 0; lk = 1'b1; end
                    else slot = (slot + 1) % 4;
                end
                exp_en = 0; exp_we = 0; exp_cack = 0; exp_vval = 0;
                while (cq.size() > 0 && cq[0].e == ec) begin
                    if (cq[0].cpu) begin
                        exp_cack = 1;
                        if (!cq[0].we) exp_crd = cq[0].d;
                    end else begin
                        exp_vval = 1;
                        exp_vrd  = cq[0].d;
                    end
                    void'(cq.pop_front());
                end
                if (mr && lk) begin
                    if (slot % 2 == 0) begin
                        if (bus.cpu_req && ec >= cpu_free) begin
                            exp_en = 1; exp_we = bus.cpu_we;
                            exp_addr = bus.cpu_addr; exp_wdata = bus.cpu_wdata;
                            if (bus.cpu_we) begin
                                mmem[int'(bus.cpu_addr)] = bus.cpu_wdata;
                                cq.push_back('{ec + 2, 1'b1, 1'b1, 8'h00});
                            end else begin
                                cq.push_back('{ec + 2, 1'b1, 1'b0, mread(bus.cpu_addr)});
                            end
                            cpu_free = ec + 4;
                        end
                    end else if (bus.vid_req && ec >= vid_free) begin
                        exp_en = 1; exp_addr = bus.vid_addr;
                        cq.push_back('{ec + 2, 1'b0, 1'b0, mread(bus.vid_addr)});
                        vid_free = ec + 4;
                    end
                end
            end
        end
    end

    // Per-cycle compare, sampled 1 time unit after each active edge.
    int   cpu_ack_cnt = 0, vid_cnt = 0, lock_t = -1;
    bit   lock_seen = 0;
    logic prev_en = 0;
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            check("mem_en", bus.mem_en, exp_en);
            check("mem_we", bus.mem_we, exp_we);
            if (exp_en) begin
                check("mem_addr", bus.mem_addr, exp_addr);
                if (exp_we) check("mem_wdata", bus.mem_wdata, exp_wdata);
            end
            check("mem_en_b2b", bus.mem_en & prev_en, 0);
            check("cpu_ack", bus.cpu_ack, exp_cack);
            check("cpu_rdata", bus.cpu_rdata, exp_crd);
            check("vid_valid", bus.vid_valid, exp_vval);
            check("vid_rdata", bus.vid_rdata, exp_vrd);
            check("locked", bus.locked, lk);
            check("sync_err", bus.sync_err, er);
            prev_en = bus.mem_en;
            if (bus.cpu_ack === 1'b1)   cpu_ack_cnt++;
            if (bus.vid_valid === 1'b1) vid_cnt++;
            if (reset_n !== 1'b1) lock_seen = 0;
            else if (bus.locked === 1'b1 && !lock_seen) begin
                lock_seen = 1;
                lock_t    = phase_t_cur;
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                              output int en_t, output int lat, output logic [7:0] rd);
        int en_i;
        bit got;
        en_i = -1; got = 0; en_t = -1; lat = -1; rd = 0;
        @(negedge CLOCK_50);
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.mem_en && bus.mem_addr == a && en_i < 0) begin
                en_i = i;
                en_t = phase_t_cur;
            end
            if (bus.cpu_ack) begin
                got = 1; rd = bus.cpu_rdata; lat = i - en_i;
            end
        end
        if (!got) timeout_fail("cpu_ack_wait");
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.cpu_req = 0; bus.cpu_we = 0;
    endtask

    task automatic vid_access(input logic [15:0] a, output int en_t, output logic [7:0] rd);
        bit got;
        got = 0; en_t = -1; rd = 0;
        @(negedge CLOCK_50);
        bus.vid_req = 1; bus.vid_addr = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.mem_en && bus.mem_addr == a && en_t < 0) en_t = phase_t_cur;
            if (bus.vid_valid) begin
                got = 1; rd = bus.vid_rdata;
            end
        end
        if (!got) timeout_fail("vid_valid_wait");
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.vid_req = 0;
    endtask

    task automatic wait_lock();
        for (int i = 0; i < 60; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.locked) return;
        end
        timeout_fail("lock_wait");
    endtask

    task automatic wait_phase(input int md, input int val);
        for (int i = 0; i < 64; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (phase_t_cur >= 0 && phase_t_cur % md == val) return;
        end
        timeout_fail("phase_wait");
    endtask

    task automatic enter_reset();
        @(posedge CLOCK_50);
        #2;
        reset_n = 0;
        vid_fault_t = -1;
        mem_fault_t = -1;
    endtask

    task automatic leave_reset();
        repeat (2) @(posedge CLOCK_50);
        #2;
        reset_n = 1;
    endtask

    initial begin
        int en_t, lat, en2, base;
        logic [7:0] rd, rd2;
        bit seen;
        reset_n = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.vid_req = 0; bus.vid_addr = 0;
        repeat (3) @(posedge CLOCK_50);
        #2;
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_sync_err", bus.sync_err, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        reset_n = 1;

        // Lock-in and 100 clean CPU cycles.
        wait_lock();
        check("lock_clock", lock_t, 8);
        repeat (1600) @(posedge CLOCK_50);
        #1;
        check("clean_sync_err", bus.sync_err, 0);

        // CPU write in slot 0, read back in slot 2.
        wait_phase(16, 5);
        cpu_access(1'b1, 16'h1234, 8'hA5, en_t, lat, rd);
        check("wr_slot0_phase", en_t % 16, 8);
        check("wr_ack_latency", lat, 2);
        cpu_access(1'b0, 16'h1234, 8'h00, en_t, lat, rd);
        check("rd_slot2_phase", en_t % 16, 0);
        check("rd_ack_latency", lat, 2);
        check("rd_data", rd, 8'hA5);

        // Video only: grants land on odd slots exclusively.
        for (int i = 0; i < 6; i++) begin
            vid_access(16'h0100 + 16'(i * 16'h0111), en_t, rd);
            check("vid_odd_slot", en_t % 8, 4);
            if (i == 0) check("vid_rd0", rd, 8'h5B);
        end

        // vid_phi glitch sets a sticky error.
        vid_fault_t = phase_t_cur + 3;
        repeat (6) @(posedge CLOCK_50);
        #1;
        check("vid_fault_err", bus.sync_err, 1);
        repeat (100) @(posedge CLOCK_50);
        #1;
        check("vid_fault_sticky", bus.sync_err, 1);

        // Both requesters waiting before lock: CPU in slot 0, video in slot 1.
        enter_reset();
        base = cpu_ack_cnt;
        en2  = vid_cnt;
        fork
            cpu_access(1'b0, 16'h2211, 8'h00, en_t, lat, rd);
            vid_access(16'h0040, lat, rd2);
            leave_reset();
        join
        check("conc_cpu_phase", en_t, 8);
        check("conc_vid_phase", lat, 12);
        check("conc_cpu_data", rd, 8'h69);
        check("conc_vid_data", rd2, 8'h1A);
        repeat (40) @(posedge CLOCK_50);
        #1;
        check("conc_cpu_pulses", cpu_ack_cnt - base, 1);
        check("conc_vid_pulses", vid_cnt - en2, 1);
        check("conc_no_err", bus.sync_err, 0);

        // Extra mem_phi rise between slot 2 and slot 3, then realignment.
        wait_phase(16, 15);
        mem_fault_t = phase_t_cur + 2;
        repeat (20) @(posedge CLOCK_50);
        #1;
        mem_fault_t = -1;
        check("extra_mem_err", bus.sync_err, 1);
        cpu_access(1'b0, 16'h1234, 8'h00, en_t, lat, rd);
        check("realign_cpu_slot", en_t % 8, 0);
        check("realign_rd_data", rd, 8'hA5);
        check("extra_mem_sticky", bus.sync_err, 1);

        // Reset at T1 of a CPU read: no ack, everything cleared.
        @(negedge CLOCK_50);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0777;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (bus.mem_en) seen = 1;
        end
        if (!seen) timeout_fail("midacc_mem_en_wait");
        base = cpu_ack_cnt;
        enter_reset();
        bus.cpu_req = 0;
        #1;
        check("midrst_mem_en", bus.mem_en, 0);
        check("midrst_cpu_ack", bus.cpu_ack, 0);
        check("midrst_cpu_rdata", bus.cpu_rdata, 0);
        check("midrst_locked", bus.locked, 0);
        check("midrst_sync_err", bus.sync_err, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        leave_reset();
        wait_lock();
        check("relock_clock", lock_t, 8);
        check("midrst_no_ack", cpu_ack_cnt - base, 0);
        repeat (10) @(posedge CLOCK_50);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
